// File: rtl/coax_tx_pkg.sv
// coax_tx_pkg: framing constants, word type and parity helper shared by the coax transmitter.
package coax_tx_pkg;
   localparam int COAX_WORD_BITS       = 10;
   localparam int COAX_START_BITS      = 5;
   localparam int COAX_VIOLATION_CELLS = 3;
   localparam int COAX_END_HOLD_CELLS  = 2;
   typedef logic [COAX_WORD_BITS-1:0] coax_word_t;
   function automatic logic coax_parity(input coax_word_t w);
      return ^w;
   endfunction
endpackage

// File: rtl/coax_tx_bit_timer.sv
// coax_tx_bit_timer: bit-cell clock divider with half-cell strobes and a half-cell index.
module coax_tx_bit_timer #(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart_i,
   output logic       half_strobe_o,
   output logic       cell_strobe_o,
   output logic       second_half_o,
   output logic [2:0] half_idx_o
);
   localparam int CW   = $clog2(CLOCKS_PER_BIT);
   localparam int HALF = CLOCKS_PER_BIT / 2;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    half_q, half_d;
   assign cell_strobe_o = cnt_q == CW'(CLOCKS_PER_BIT - 1);
   assign half_strobe_o = cell_strobe_o || cnt_q == CW'(HALF - 1);
   // Position outputs describe the upcoming clock so the owner can register its line level.
   assign cnt_d         = (restart_i || cell_strobe_o) ? '0 : cnt_q + CW'(1);
   assign half_d        = restart_i ? 3'd0 : half_strobe_o ? half_q + 3'd1 : half_q;
   assign second_half_o = cnt_d >= CW'(HALF);
   assign half_idx_o    = half_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         half_q <= 3'd0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end
endmodule

// File: rtl/coax_tx.sv
// coax_tx: 3270 coax transmitter; frames 10-bit words with start, violation, sync, parity
// and end sequences and emits the Manchester-encoded line level.
module coax_tx
   import coax_tx_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [COAX_WORD_BITS-1:0] data,
   input  logic                      valid,
   output logic                      ready,
   output logic                      active,
   output logic                      tx
);
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_VIOLATION = 3'd2;
   localparam logic [2:0] ST_SYNC      = 3'd3;
   localparam logic [2:0] ST_DATA      = 3'd4;
   localparam logic [2:0] ST_PARITY    = 3'd5;
   localparam logic [2:0] ST_END       = 3'd6;

   logic [2:0] state_q, state_d;
   logic [3:0] cell_q, cell_d;
   coax_word_t hold_q, hold_d, shift_q, shift_d;
   logic       full_q, full_d, par_q, par_d, tx_q, tx_d, active_q;
   logic       hs, load, restart, last_cell, advance, bit_nxt;
   logic       half_strobe, cell_strobe, second_half;
   logic [2:0] half_idx;

   coax_tx_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .restart_i    (restart),
      .half_strobe_o(half_strobe),
      .cell_strobe_o(cell_strobe),
      .second_half_o(second_half),
      .half_idx_o   (half_idx)
   );

   assign ready  = !full_q && !reset;
   assign active = active_q;
   assign tx     = tx_q;
   assign hs     = valid && ready;

   always_comb begin
      case (state_q)
         ST_START:     last_cell = cell_q == 4'(COAX_START_BITS - 1);
         ST_VIOLATION: last_cell = cell_q == 4'(COAX_VIOLATION_CELLS - 1);
         ST_DATA:      last_cell = cell_q == 4'(COAX_WORD_BITS - 1);
         ST_END:       last_cell = cell_q == 4'(COAX_END_HOLD_CELLS);
         default:      last_cell = 1'b1;
      endcase
      advance = cell_strobe && last_cell;
      case (state_q)
         ST_IDLE:      state_d = full_q ? ST_START : ST_IDLE;
         ST_START:     state_d = advance ? ST_VIOLATION : state_q;
         ST_VIOLATION: state_d = advance ? ST_SYNC : state_q;
         ST_SYNC:      state_d = advance ? ST_DATA : state_q;
         ST_DATA:      state_d = advance ? ST_PARITY : state_q;
         // Continuation sees full as it was before any handshake on this same edge.
         ST_PARITY:    state_d = advance ? (full_q ? ST_SYNC : ST_END) : state_q;
         ST_END:       state_d = advance ? ST_IDLE : state_q;
         default:      state_d = ST_IDLE;
      endcase
   end

   assign restart = state_q == ST_IDLE || state_d != state_q;
   assign load    = state_d == ST_SYNC && state_q != ST_SYNC;
   assign cell_d  = restart ? 4'd0 : cell_strobe ? cell_q + 4'd1 : cell_q;
   assign full_d  = hs || (full_q && !load);
   assign hold_d  = hs ? data : hold_q;
   assign shift_d = load ? hold_q : (state_q == ST_DATA && cell_strobe) ? shift_q << 1 : shift_q;
   assign par_d   = load ? coax_parity(hold_q) : par_q;

   // Line level for the upcoming clock, from the next state and timer position.
   assign bit_nxt = state_d == ST_DATA ? shift_d[COAX_WORD_BITS-1]
                  : state_d == ST_PARITY ? par_q
                  : state_d != ST_END;
   assign tx_d    = state_d == ST_IDLE ? 1'b0
                  : state_d == ST_VIOLATION ? half_idx >= 3'd3
                  : (state_d == ST_END && cell_d != 4'd0) ? 1'b1
                  : second_half ? bit_nxt : !bit_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cell_q   <= 4'd0;
         hold_q   <= '0;
         shift_q  <= '0;
         full_q   <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cell_q   <= cell_d;
         hold_q   <= hold_d;
         shift_q  <= shift_d;
         full_q   <= full_d;
         par_q    <= par_d;
         tx_q     <= (half_strobe || state_q == ST_IDLE) ? tx_d : tx_q;
         active_q <= state_d != ST_IDLE;
      end
   end
endmodule

// File: tb/tb_coax_tx.sv
// tb_coax_tx: directed and randomized frames for coax_tx compared against a cell-level line model.
module tb_coax_tx;
   logic       clk = 1'b0, reset = 1'b1;
   logic [9:0] data = '0, data16 = '0;
   logic       valid = 1'b0, valid16 = 1'b0;
   logic       ready, active, tx, ready16, active16, tx16;
   int         tests = 0, fails = 0;
   logic       line_q[$], exp_q[$];
   int         flen[$], exp_len[$], gap[$];
   int         cur_len = 0, idle_run = 0, idle_tx_err = 0;

   always #5 clk = ~clk;

   coax_tx #(.CLOCKS_PER_BIT(8)) dut (
      .clk(clk), .reset(reset), .data(data), .valid(valid),
      .ready(ready), .active(active), .tx(tx)
   );
   coax_tx #(.CLOCKS_PER_BIT(16)) dut16 (
      .clk(clk), .reset(reset), .data(data16), .valid(valid16),
      .ready(ready16), .active(active16), .tx(tx16)
   );

   // Splits the 8-clock DUT's line into frames and inter-frame gaps.
   always @(negedge clk) begin
      if (active) begin
         if (cur_len == 0 && flen.size() > 0) gap.push_back(idle_run);
         line_q.push_back(tx);
         cur_len++;
         idle_run = 0;
      end else begin
         if (cur_len > 0) begin
            flen.push_back(cur_len);
            cur_len = 0;
         end
         idle_run++;
         if (tx !== 1'b0 && !reset) idle_tx_err++;
      end
   end

   function automatic void put(input int n, input logic v);
      repeat (n) exp_q.push_back(v);
   endfunction

   function automatic void enc(input int cpb, input logic b);
      put(cpb / 2, !b);
      put(cpb / 2, b);
   endfunction

   function automatic void model_frame(input int cpb, input int n, input logic [9:0] w[3]);
      int n0 = exp_q.size();
      for (int i = 0; i < 5; i++) enc(cpb, 1'b1);
      put(3 * cpb / 2, 1'b0);
      put(3 * cpb / 2, 1'b1);
      for (int k = 0; k < n; k++) begin
         enc(cpb, 1'b1);
         for (int i = 9; i >= 0; i--) enc(cpb, w[k][i]);
         enc(cpb, ($countones(w[k]) % 2) == 1);
      end
      enc(cpb, 1'b0);
      put(2 * cpb, 1'b1);
      exp_len.push_back(exp_q.size() - n0);
   endfunction

   task automatic clear_mon();
      @(posedge clk);
      line_q.delete(); exp_q.delete(); flen.delete(); exp_len.delete(); gap.delete();
      cur_len = 0; idle_run = 0; idle_tx_err = 0;
      @(negedge clk);
   endtask

   task automatic push(input logic [9:0] w);
      int n = 0;
      data = w;
      valid = 1'b1;
      while (!ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      valid = 1'b0;
      if (n >= 2000) begin
         tests++; fails++;
         $display("FAIL push_timeout ready stayed %b for %0d cycles, required 1", ready, n);
      end
   endtask

   task automatic wait_done();
      int n = 0, quiet = 0;
      while (quiet < 40 && n < 5000) begin
         @(negedge clk);
         n++;
         quiet = active ? 0 : quiet + 1;
      end
      if (quiet < 40) begin
         tests++; fails++;
         $display("FAIL frame_timeout active=%b after %0d cycles, required 0", active, n);
      end
   endtask

   task automatic check_line(input string name);
      int bad = -1;
      int m;
      tests++;
      if (flen.size() != exp_len.size()) bad = 0;
      else foreach (flen[i]) if (bad < 0 && flen[i] != exp_len[i]) bad = i;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s_frames got %0d frames (first %0d clocks), required %0d frames (first %0d clocks)",
                  name, flen.size(), flen.size() > 0 ? flen[0] : -1, exp_len.size(), exp_len[0]);
      end
      tests++;
      bad = -1;
      m = line_q.size() < exp_q.size() ? line_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) if (bad < 0 && line_q[i] !== exp_q[i]) bad = i;
      if (bad < 0 && line_q.size() != exp_q.size()) bad = m;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s_line differs at sample %0d: got %b (%0d samples), required %b (%0d samples)", name, bad,
                  bad < line_q.size() ? line_q[bad] : 1'bx, line_q.size(),
                  bad < exp_q.size() ? exp_q[bad] : 1'bx, exp_q.size());
      end
      tests++;
      if (idle_tx_err != 0) begin
         fails++;
         $display("FAIL %s_idle_tx got %0d inactive cycles with tx=1, required 0", name, idle_tx_err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests += 3;
      if (active !== 1'b0) begin fails++; $display("FAIL reset_active got %b required 0", active); end
      if (tx !== 1'b0)     begin fails++; $display("FAIL reset_tx got %b required 0", tx); end
      if (ready !== 1'b0)  begin fails++; $display("FAIL reset_ready got %b required 0", ready); end
      reset = 1'b0;
      @(negedge clk);
      tests += 2;
      if (ready !== 1'b1)   begin fails++; $display("FAIL release_ready got %b required 1", ready); end
      if (ready16 !== 1'b1) begin fails++; $display("FAIL release_ready16 got %b required 1", ready16); end
   endtask

   task automatic test_single(input string name, input logic [9:0] w);
      logic [9:0] ws[3];
      ws = '{w, 10'h0, 10'h0};
      clear_mon();
      push(w);
      tests++;
      if (ready !== 1'b0) begin fails++; $display("FAIL %s_ready_drop got %b required 0", name, ready); end
      wait_done();
      model_frame(8, 1, ws);
      check_line(name);
   endtask

   task automatic test_back_to_back();
      logic [9:0] ws[3];
      ws = '{10'h3FF, 10'h155, 10'h0};
      clear_mon();
      push(ws[0]);
      repeat (96) @(negedge clk);
      tests++;
      if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_in_data got %b required 1", ready); end
      push(ws[1]);
      wait_done();
      model_frame(8, 2, ws);
      check_line("back_to_back");
   endtask

   task automatic test_random();
      logic [9:0] ws[3];
      int n;
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(1, 3);
         for (int k = 0; k < 3; k++) ws[k] = 10'($urandom);
         clear_mon();
         for (int k = 0; k < n; k++) push(ws[k]);
         wait_done();
         model_frame(8, n, ws);
         check_line("random");
      end
   endtask

   task automatic test_late(input string name, input int offset, input bit split);
      logic [9:0] ws[3], w2[3];
      ws = '{10'h2C3, 10'h0A5, 10'h0};
      w2 = '{10'h0A5, 10'h0, 10'h0};
      clear_mon();
      push(ws[0]);
      repeat (offset) @(negedge clk);
      push(ws[1]);
      wait_done();
      if (split) begin
         model_frame(8, 1, ws);
         model_frame(8, 1, w2);
      end else model_frame(8, 2, ws);
      check_line(name);
      tests++;
      if (gap.size() != exp_len.size() - 1 || (gap.size() > 0 && gap[0] < 1)) begin
         fails++;
         $display("FAIL %s_gap got %0d gaps (first %0d clocks), required %0d gaps of >=1 clock",
                  name, gap.size(), gap.size() > 0 ? gap[0] : -1, exp_len.size() - 1);
      end
   endtask

   task automatic test_reset_mid();
      int n_act = 0;
      clear_mon();
      push(10'h2AA);
      push(10'h0F0);
      repeat (30) @(negedge clk);
      tests++;
      if (active !== 1'b1) begin fails++; $display("FAIL midreset_pre_active got %b required 1", active); end
      reset = 1'b1;
      @(negedge clk);
      tests += 3;
      if (active !== 1'b0) begin fails++; $display("FAIL midreset_active got %b required 0", active); end
      if (tx !== 1'b0)     begin fails++; $display("FAIL midreset_tx got %b required 0", tx); end
      if (ready !== 1'b0)  begin fails++; $display("FAIL midreset_ready got %b required 0", ready); end
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (ready !== 1'b1) begin fails++; $display("FAIL midreset_release_ready got %b required 1", ready); end
      repeat (300) begin
         @(negedge clk);
         if (active || tx) n_act++;
      end
      tests++;
      if (n_act != 0) begin fails++; $display("FAIL midreset_quiet got %0d active cycles, required 0", n_act); end
   endtask

   task automatic test_cpb16();
      logic [9:0] ws[3];
      logic       got[$];
      int         bad = -1;
      ws = '{10'h001, 10'h0, 10'h0};
      clear_mon();
      data16 = ws[0];
      valid16 = 1'b1;
      @(negedge clk);
      valid16 = 1'b0;
      tests++;
      if (ready16 !== 1'b0) begin fails++; $display("FAIL cpb16_ready_drop got %b required 0", ready16); end
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         if (i == 128) begin
            tests++;
            if (ready16 !== 1'b0) begin fails++; $display("FAIL cpb16_ready_before_load got %b required 0", ready16); end
         end
         if (i == 129) begin
            tests++;
            if (ready16 !== 1'b1) begin fails++; $display("FAIL cpb16_ready_after_load got %b required 1", ready16); end
         end
         if (active16) got.push_back(tx16);
      end
      model_frame(16, 1, ws);
      tests++;
      if (got.size() != 368) begin fails++; $display("FAIL cpb16_len got %0d clocks required 368", got.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL cpb16_line differs at sample %0d: got %b required %b", bad, got[bad], exp_q[bad]);
      end
   endtask

   initial begin
      test_reset();
      test_single("word_2aa", 10'h2AA);
      test_single("word_000", 10'h000);
      test_back_to_back();
      test_random();
      test_late("late_continue", 159, 1'b0);
      test_late("late_last_parity", 160, 1'b1);
      test_reset_mid();
      test_cpb16();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
